// File: rtl/banked_register_file.sv
// Banked multi-port register file.
//
// Holds NUM_THREADS x REGS_PER_THREAD entries of DATA_WIDTH bits. It has
// NUM_READ_PORTS registered read ports and one write port. After reset, a
// hardware sequence walks every entry and writes zero to it. Reads and
// writes are honoured only once that sequence has finished.
//
// Ports:
//   clk                 - clock; all logic is on the rising edge
//   reset               - synchronous, active-low reset
//   ds_read_en          - per-port read enable; a port whose enable is low holds its output
//   ds_read_sel         - per-port {thread, reg} index; port p is at [p*IDX_W +: IDX_W]
//   rf_read_value       - per-port registered read data; port p is at [p*DATA_WIDTH +: DATA_WIDTH]
//   wb_writeback_reg    - write index {thread, reg}
//   wb_writeback_value  - write data
//   wb_enable_writeback - write strobe
//   rf_ready            - high once the clear sequence has completed
module banked_register_file #(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned NUM_THREADS     = 4,
    parameter int unsigned REGS_PER_THREAD = 32,
    parameter int unsigned NUM_READ_PORTS  = 2,
    parameter bit          BYPASS_EN       = 1'b1,
    localparam int unsigned TOTAL          = NUM_THREADS * REGS_PER_THREAD,
    localparam int unsigned IDX_W          = $clog2(TOTAL)
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_READ_PORTS-1:0]            ds_read_en,
    input  logic [NUM_READ_PORTS*IDX_W-1:0]      ds_read_sel,
    output logic [NUM_READ_PORTS*DATA_WIDTH-1:0] rf_read_value,
    input  logic [IDX_W-1:0]                     wb_writeback_reg,
    input  logic [DATA_WIDTH-1:0]                wb_writeback_value,
    input  logic                                 wb_enable_writeback,
    output logic                                 rf_ready
);

    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(TOTAL - 1);

    typedef enum logic [0:0] {StClear, StReady} state_e;

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        clear_ptr_q, clear_ptr_d;
    logic                    rf_ready_q, rf_ready_d;

    logic [DATA_WIDTH-1:0]   mem_q [TOTAL];
    logic                    mem_we;
    logic [IDX_W-1:0]        mem_waddr;
    logic [DATA_WIDTH-1:0]   mem_wdata;

    // ------------------------------------------------------------------
    // Clear sequencer
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        clear_ptr_d = clear_ptr_q;
        rf_ready_d  = rf_ready_q;
        unique case (state_q)
            StClear: begin
                clear_ptr_d = clear_ptr_q + IDX_W'(1);
                if (clear_ptr_q == LastIdx) begin
                    state_d    = StReady;
                    rf_ready_d = 1'b1;
                end
            end
            StReady: begin
                state_d = StReady;
            end
            default: begin
                state_d = StClear;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= StClear;
            clear_ptr_q <= '0;
            rf_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            clear_ptr_q <= clear_ptr_d;
            rf_ready_q  <= rf_ready_d;
        end
    end

    assign rf_ready = rf_ready_q;

    // ------------------------------------------------------------------
    // Storage write port: the clear walker owns it until READY.
    // Reset itself never touches the contents.
    // ------------------------------------------------------------------
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = wb_writeback_reg;
        mem_wdata = wb_writeback_value;
        if (reset) begin
            if (state_q == StClear) begin
                mem_we    = 1'b1;
                mem_waddr = clear_ptr_q;
                mem_wdata = '0;
            end else if (wb_enable_writeback) begin
                mem_we = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Read ports with per-port enable hold and optional write bypass
    // ------------------------------------------------------------------
    for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_rd
        logic [IDX_W-1:0]      rd_sel;
        logic [DATA_WIDTH-1:0] rd_q, rd_d;

        assign rd_sel = ds_read_sel[p*IDX_W +: IDX_W];

        always_comb begin
            rd_d = rd_q;
            if ((state_q == StReady) && ds_read_en[p]) begin
                // The array is read before the edge, so without bypass a
                // same-cycle write naturally yields the old contents.
                if (BYPASS_EN && wb_enable_writeback && (wb_writeback_reg == rd_sel)) begin
                    rd_d = wb_writeback_value;
                end else begin
                    rd_d = mem_q[rd_sel];
                end
            end
        end

        always_ff @(posedge clk) begin
            if (!reset) begin
                rd_q <= '0;
            end else begin
                rd_q <= rd_d;
            end
        end

        assign rf_read_value[p*DATA_WIDTH +: DATA_WIDTH] = rd_q;
    end

endmodule
